module_bin_bcd: RTL and testbench
=================================

// Module: module_bin_bcd
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3). Produces the four BCD digits and the
//  listo strobe consumed by the 7-segment display driver (unidades..millares, listo).
//  Takes one binary word per inicio request and converts it over W_BIN cycles.
//  Input values above 9999 are flagged and saturated to 9999 on the display.
// PARAMETERS
//  W_BIN   14   width of binario. Legal range 4..14. 14 covers 0..9999 plus overflow values.
// PORTS
//  clk             in   1    system clock, all logic on rising edge
//  rst             in   1    reset, asynchronous, active-high
//  binario         in   W_BIN unsigned binary value to convert, sampled only when accepted
//  inicio          in   1    conversion request
//  unidades        out  4    BCD ones digit, registered
//  decenas         out  4    BCD tens digit, registered
//  centenas        out  4    BCD hundreds digit, registered
//  millares        out  4    BCD thousands digit, registered
//  listo           out  1    one-cycle pulse: the digit outputs have just been updated
//  ocupado         out  1    conversion in progress; ocupado = (state != IDLE)
//  desborde        out  1    registered with the digits: 1 when the last input was > 9999
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, all digits=0, listo=0, desborde=0, internal shift reg=0.
//  FSM states: IDLE, DESPL, FIN.
//   IDLE : if inicio=1 at an edge -> latch binario into shift reg, shift count=0, latch the
//          overflow compare (binario > 9999), go DESPL. If inicio=0 -> stay in IDLE.
//   DESPL: each edge -> add 3 to every BCD nibble that is >= 5, then shift {bcd,bin} left by 1.
//          Count shifts. After the W_BIN-th shift -> go FIN.
//   FIN  : one edge -> load the digit outputs from the BCD nibbles. If overflow: load 9,9,9,9.
//          At the same edge: desborde <= overflow, listo <= 1, go IDLE.
//  listo is cleared at every edge that is not the FIN->IDLE edge. This gives an exact 1-cycle pulse.
//  Latency: inicio accepted at edge N. Shifts at edges N+1..N+W_BIN.
//   Outputs and listo change at edge N+W_BIN+1, which is edge N+15 at default width.
//  Throughput: a new inicio is accepted in the cycle where listo=1, since state is already IDLE.
//   Back-to-back conversion period is W_BIN+2 cycles.
//  inicio while ocupado=1 is ignored and is not queued.
//   A change on binario after acceptance has no effect on the conversion in progress.
//  The digit outputs and desborde hold their last values between conversions.
//   They change only at the FIN edge, so the display never shows partial results.
//  Each digit output is always in the range 0..9. Overflow is checked only when W_BIN = 14.
//   For a smaller W_BIN, desborde stays 0.
//  The 4 internal BCD nibbles are wide enough for 9999. Overflowing inputs convert wrong
//   internally, but that result is discarded by the saturation in FIN.
//  rst during DESPL or FIN aborts the conversion. No listo pulse is issued for it.
//   The outputs go to 0 immediately, without waiting for a clock edge.
// TESTING
//  1. Assert rst with clk stopped -> digits=0, listo=0, ocupado=0, desborde=0 with no clock edge.
//  2. binario=1234, inicio pulse -> ocupado=1 for 15 cycles. listo=1 for exactly 1 cycle at edge N+15.
//     Then millares=1, centenas=2, decenas=3, unidades=4, desborde=0. Values held for 50 more cycles.
//  3. Boundaries: binario=0 gives digits 0,0,0,0. binario=9999 gives 9,9,9,9 with desborde=0.
//     binario=1000 gives 1,0,0,0, and binario=9 gives 0,0,0,9.
//  4. Overflow: binario=10000 and binario=16383 each give digits 9,9,9,9 and desborde=1.
//     A following binario=42 gives 0,0,4,2 and clears desborde to 0.
//  5. Handshake: inicio held high with binario changing 77->88 mid-conversion -> result 0,0,7,7.
//     No extra listo pulse appears. Then inicio in the listo cycle with binario=55 -> second result 0,0,5,5.
//     That result arrives 16 cycles after the first listo.
//  6. Start 4321 and assert rst after 7 shift edges -> outputs immediately 0, no listo pulse.
//     A fresh inicio with 4321 afterwards gives 4,3,2,1 with normal latency.

Source files
------------

// File: rtl/module_bin_bcd_if.sv
// Interface bundling the request side and the display-digit side of the
// binary-to-BCD converter.
//   binario  : unsigned value to convert (driven by requester)
//   inicio   : conversion request (driven by requester)
//   unidades, decenas, centenas, millares : registered BCD digits (driven by converter)
//   listo    : one-cycle pulse, digits just updated (driven by converter)
//   ocupado  : conversion in progress (driven by converter)
//   desborde : last accepted input exceeded 9999 (driven by converter)
interface module_bin_bcd_if #(
    parameter int W_BIN = 14
);
    logic [W_BIN-1:0] binario;
    logic             inicio;
    logic [3:0]       unidades;
    logic [3:0]       decenas;
    logic [3:0]       centenas;
    logic [3:0]       millares;
    logic             listo;
    logic             ocupado;
    logic             desborde;

    modport master (
        output binario, inicio,
        input  unidades, decenas, centenas, millares, listo, ocupado, desborde
    );

    modport slave (
        input  binario, inicio,
        output unidades, decenas, centenas, millares, listo, ocupado, desborde
    );
endinterface

// File: rtl/module_bin_bcd.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// One binary word is accepted per inicio request while idle and converted over
// W_BIN shift cycles; the digit outputs update together one cycle later with a
// single-cycle listo pulse. Inputs above 9999 saturate the display to 9999 and
// raise desborde.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : module_bin_bcd_if.slave (binario/inicio in; digits, listo,
//          ocupado, desborde out)
module module_bin_bcd #(
    parameter int W_BIN = 14
) (
    input  logic             clk,
    input  logic             rst,
    module_bin_bcd_if.slave  bus
);
    // Shift register layout: {millares, centenas, decenas, unidades, binary}
    localparam int SW = 16 + W_BIN;

    typedef enum logic [1:0] {
        IDLE,
        DESPL,
        FIN
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [SW-1:0]   shift_reg;
    logic [SW-1:0]   adjusted;
    logic [3:0]      count_reg;
    logic            ovf_reg;
    logic            ovf_in;
    logic            last_shift;
    logic [3:0]      unidades_reg;
    logic [3:0]      decenas_reg;
    logic [3:0]      centenas_reg;
    logic [3:0]      millares_reg;
    logic            listo_reg;
    logic            desborde_reg;

    assign last_shift = (count_reg == 4'(W_BIN - 1));

    // Add-3 correction applied to every BCD nibble before each shift.
    assign adjusted[W_BIN-1:0] = shift_reg[W_BIN-1:0];
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_add3
            logic [3:0] nibble;
            assign nibble = shift_reg[W_BIN + 4*gi +: 4];
            assign adjusted[W_BIN + 4*gi +: 4] = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
        end
    endgenerate

    // Only a 14-bit input can exceed 9999; narrower inputs never overflow.
    generate
        if (W_BIN >= 14) begin : g_ovf
            assign ovf_in = (bus.binario > W_BIN'(9999));
        end else begin : g_no_ovf
            assign ovf_in = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.inicio) state_next = DESPL;
            DESPL:   if (last_shift) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg    <= '0;
            count_reg    <= '0;
            ovf_reg      <= 1'b0;
            unidades_reg <= 4'd0;
            decenas_reg  <= 4'd0;
            centenas_reg <= 4'd0;
            millares_reg <= 4'd0;
            listo_reg    <= 1'b0;
            desborde_reg <= 1'b0;
        end else begin
            // listo is high only on the cycle right after the FIN edge.
            listo_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.inicio) begin
                        shift_reg <= {16'd0, bus.binario};
                        count_reg <= 4'd0;
                        ovf_reg   <= ovf_in;
                    end
                end
                DESPL: begin
                    shift_reg <= adjusted << 1;
                    count_reg <= count_reg + 4'd1;
                end
                FIN: begin
                    // An overflowing input leaves garbage in the nibbles; show 9999.
                    if (ovf_reg) begin
                        unidades_reg <= 4'd9;
                        decenas_reg  <= 4'd9;
                        centenas_reg <= 4'd9;
                        millares_reg <= 4'd9;
                    end else begin
                        unidades_reg <= shift_reg[W_BIN      +: 4];
                        decenas_reg  <= shift_reg[W_BIN + 4  +: 4];
                        centenas_reg <= shift_reg[W_BIN + 8  +: 4];
                        millares_reg <= shift_reg[W_BIN + 12 +: 4];
                    end
                    desborde_reg <= ovf_reg;
                    listo_reg    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.unidades = unidades_reg;
    assign bus.decenas  = decenas_reg;
    assign bus.centenas = centenas_reg;
    assign bus.millares = millares_reg;
    assign bus.listo    = listo_reg;
    assign bus.desborde = desborde_reg;
    assign bus.ocupado  = (state_reg != IDLE);
endmodule

// File: tb/tb_module_bin_bcd.sv
// Self-checking bench for module_bin_bcd: reset behaviour, table of boundary
// vectors, randomized values against an arithmetic reference, handshake and
// mid-conversion reset sequences.
module tb_module_bin_bcd;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clk_run = 1'b0;

    module_bin_bcd_if #(.W_BIN(14)) bus ();

    module_bin_bcd #(.W_BIN(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [13:0] bin;
        logic [3:0]  m;
        logic [3:0]  c;
        logic [3:0]  d;
        logic [3:0]  u;
        logic        ovf;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {15'd0, bus.desborde, bus.millares, bus.centenas, bus.decenas, bus.unidades};
    endfunction

    // Reference: plain decimal arithmetic with saturation at 9999.
    function automatic logic [31:0] model(input int v);
        int s;
        logic o;
        o = (v > 9999);
        s = o ? 9999 : v;
        return {15'd0, o, 4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    // Request a conversion and wait for listo; lat counts edges from acceptance
    // to the listo edge, busy counts post-edge samples with ocupado=1.
    task automatic run_conv(input logic [13:0] v, output int lat, output int busy);
        @(negedge clk);
        bus.binario = v;
        bus.inicio  = 1'b1;
        @(posedge clk);
        #1;
        bus.inicio = 1'b0;
        lat  = 0;
        busy = 0;
        while (!bus.listo && lat < 40) begin
            if (bus.ocupado) busy++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat, busy, k, held_bad, pulses, gap;
        logic [31:0] snap;

        bus.binario = '0;
        bus.inicio  = 1'b0;

        tbl[0] = '{14'd0,     4'd0, 4'd0, 4'd0, 4'd0, 1'b0};
        tbl[1] = '{14'd9999,  4'd9, 4'd9, 4'd9, 4'd9, 1'b0};
        tbl[2] = '{14'd1000,  4'd1, 4'd0, 4'd0, 4'd0, 1'b0};
        tbl[3] = '{14'd9,     4'd0, 4'd0, 4'd0, 4'd9, 1'b0};
        tbl[4] = '{14'd10000, 4'd9, 4'd9, 4'd9, 4'd9, 1'b1};
        tbl[5] = '{14'd16383, 4'd9, 4'd9, 4'd9, 4'd9, 1'b1};
        tbl[6] = '{14'd42,    4'd0, 4'd0, 4'd4, 4'd2, 1'b0};
        tbl[7] = '{14'd1234,  4'd1, 4'd2, 4'd3, 4'd4, 1'b0};

        // Reset with clock stopped.
        #2 rst = 1'b1;
        #1;
        check("reset_digits", outs(), 32'h0);
        check("reset_listo", {31'd0, bus.listo}, 32'd0);
        check("reset_ocupado", {31'd0, bus.ocupado}, 32'd0);
        clk_run = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Basic conversion with latency, busy length, pulse width and hold.
        run_conv(14'd1234, lat, busy);
        check("t2_latency", lat, 15);
        check("t2_busy_cycles", busy, 15);
        check("t2_digits", outs(), 32'h01234);
        @(posedge clk);
        #1;
        check("t2_listo_width", {31'd0, bus.listo}, 32'd0);
        snap = outs();
        held_bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (outs() !== snap || bus.listo !== 1'b0) held_bad++;
        end
        check("t2_hold_50", held_bad, 0);

        // Boundary and overflow table.
        for (int i = 0; i < 8; i++) begin
            run_conv(tbl[i].bin, lat, busy);
            check($sformatf("tbl_%0d_latency", tbl[i].bin), lat, 15);
            check($sformatf("tbl_%0d_digits", tbl[i].bin), outs(),
                  {15'd0, tbl[i].ovf, tbl[i].m, tbl[i].c, tbl[i].d, tbl[i].u});
        end

        // Randomized values against the arithmetic reference.
        for (int i = 0; i < 30; i++) begin
            logic [13:0] v;
            v = 14'($urandom_range(0, 16383));
            run_conv(v, lat, busy);
            check($sformatf("rnd_%0d", v), outs(), model(int'(v)));
        end

        // Handshake: inicio held, binario changes mid-conversion, then
        // back-to-back request in the listo cycle.
        @(negedge clk);
        bus.binario = 14'd77;
        bus.inicio  = 1'b1;
        @(posedge clk);
        #1;
        k = 0;
        while (!bus.listo && k < 40) begin
            if (k == 5) bus.binario = 14'd88;
            @(posedge clk);
            #1;
            k++;
        end
        check("t5_first_latency", k, 15);
        check("t5_first_digits", outs(), 32'h00077);
        bus.binario = 14'd55;
        @(posedge clk);
        #1;
        bus.inicio = 1'b0;
        gap = 1;
        pulses = 0;
        while (!bus.listo && gap < 40) begin
            @(posedge clk);
            #1;
            gap++;
        end
        check("t5_second_gap", gap, 16);
        check("t5_second_digits", outs(), 32'h00055);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.listo) pulses++;
        end
        check("t5_no_extra_listo", pulses, 0);

        // Reset mid-conversion: immediate clear, no listo pulse.
        @(negedge clk);
        bus.binario = 14'd4321;
        bus.inicio  = 1'b1;
        @(posedge clk);
        #1;
        bus.inicio = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_async_digits", outs(), 32'h0);
        check("t6_async_ocupado", {31'd0, bus.ocupado}, 32'd0);
        check("t6_async_listo", {31'd0, bus.listo}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.listo) pulses++;
        end
        check("t6_no_listo", pulses, 0);
        run_conv(14'd4321, lat, busy);
        check("t6_fresh_latency", lat, 15);
        check("t6_fresh_digits", outs(), 32'h04321);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
